// File: rtl/sparse_conv_layer_sched.sv
// Layer controller: per kernel pass clears the datapath, streams a feature map, waits for the result, then strobes a store.
// All outputs registered (start -> dp_clear in 1 cycle); no back-pressure on the feature stream, abort cancels within 1 cycle.
module sparse_conv_layer_sched #(
  parameter int IMG_PIXELS  = 784,
  parameter int ADDR_W      = 10,
  parameter int KSEL_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KSEL_W-1:0] num_kernels,
  input  logic              abort,
  input  logic              dp_done,
  output logic              dp_clear,
  output logic              feat_rd_en,
  output logic [ADDR_W-1:0] feat_rd_addr,
  output logic              feature_in_valid,
  output logic [KSEL_W-1:0] kernel_sel,
  output logic              result_we,
  output logic [KSEL_W-1:0] result_idx,
  output logic              busy,
  output logic              layer_done,
  output logic              timeout_err
);

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pix_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [KSEL_W-1:0]   kcnt;
  logic [KSEL_W-1:0]   nk_q;
  logic                done_q;

  logic                done_edge;
  logic                pix_last;
  logic                wait_last;
  logic                pass_last;
  logic                start_acc;
  logic                timeout_hit;

  always_comb begin
    done_edge = dp_done & ~done_q;
    pix_last  = (pix_cnt == ADDR_W'(IMG_PIXELS - 1));
    wait_last = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
    pass_last = (kcnt == nk_q - KSEL_W'(1));
    start_acc = (state == S_IDLE) && start;
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_kernels != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: state_nxt = S_LOAD;
      S_LOAD: begin
        if (pix_last) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_edge) begin
          state_nxt = S_STORE;
        end else if (wait_last) begin
          state_nxt   = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_STORE: state_nxt = pass_last ? S_DONE : S_CLEAR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // abort overrides whatever the pass was about to do
    if (abort && (state != S_IDLE) && (state != S_DONE)) begin
      state_nxt   = S_IDLE;
      timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      pix_cnt          <= '0;
      wait_cnt         <= '0;
      kcnt             <= '0;
      nk_q             <= '0;
      done_q           <= 1'b0;
      dp_clear         <= 1'b0;
      feat_rd_en       <= 1'b0;
      feature_in_valid <= 1'b0;
      result_we        <= 1'b0;
      result_idx       <= '0;
      busy             <= 1'b0;
      layer_done       <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      state            <= state_nxt;
      dp_clear         <= (state_nxt == S_CLEAR);
      feat_rd_en       <= (state_nxt == S_LOAD);
      feature_in_valid <= feat_rd_en;
      result_we        <= (state_nxt == S_STORE);
      layer_done       <= (state_nxt == S_DONE);
      busy             <= (state_nxt != S_IDLE);

      if (start_acc) begin
        timeout_err <= 1'b0;
        if (num_kernels != '0) begin
          nk_q <= num_kernels;
          kcnt <= '0;
        end
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
      end

      if (state == S_CLEAR) begin
        pix_cnt <= '0;
      end else if ((state == S_LOAD) && !pix_last) begin
        pix_cnt <= pix_cnt + ADDR_W'(1);
      end

      // tracked through LOAD too, so a level already high at WAIT entry is not an edge
      done_q <= (state == S_CLEAR) ? 1'b0 : dp_done;

      if (state == S_LOAD) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (state_nxt == S_STORE) begin
        result_idx <= kcnt;
      end
      if ((state == S_STORE) && (state_nxt == S_CLEAR)) begin
        kcnt <= kcnt + KSEL_W'(1);
      end
    end
  end

  assign feat_rd_addr = pix_cnt;
  assign kernel_sel   = kcnt;

endmodule

// File: tb/tb_sparse_conv_layer_sched.sv
// Directed bench for sparse_conv_layer_sched: each scenario task drives stimulus and checks its own expectations.
module tb_sparse_conv_layer_sched;

  localparam int IMG = 784;
  localparam int TO  = 4096;

  logic       clk = 1'b0;
  logic       rst, start, abort, dp_done;
  logic [7:0] num_kernels;
  logic       dp_clear, feat_rd_en, feature_in_valid, result_we, busy, layer_done, timeout_err;
  logic [9:0] feat_rd_addr;
  logic [7:0] kernel_sel, result_idx;

  int vectors = 0;
  int errors  = 0;
  int n_we    = 0;
  int n_done  = 0;
  int n_clr   = 0;

  sparse_conv_layer_sched dut (
    .clk(clk), .rst(rst), .start(start), .num_kernels(num_kernels), .abort(abort),
    .dp_done(dp_done), .dp_clear(dp_clear), .feat_rd_en(feat_rd_en),
    .feat_rd_addr(feat_rd_addr), .feature_in_valid(feature_in_valid),
    .kernel_sel(kernel_sel), .result_we(result_we), .result_idx(result_idx),
    .busy(busy), .layer_done(layer_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // event counters sampled on each edge (values of the cycle just ending)
  always @(posedge clk) begin
    if (result_we)  n_we   = n_we + 1;
    if (layer_done) n_done = n_done + 1;
    if (dp_clear)   n_clr  = n_clr + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts;
    n_we = 0; n_done = 0; n_clr = 0;
  endtask

  task automatic test_reset;
    logic [39:0] all_out;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dp_done = 1'b0; num_kernels = 8'd0;
    tick; tick;
    all_out = {dp_clear, feat_rd_en, feat_rd_addr, feature_in_valid, kernel_sel,
               result_we, result_idx, busy, layer_done, timeout_err};
    vectors++;
    if (all_out !== 40'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int bad_rd = 0;
    clr_counts();
    num_kernels = 8'd1; start = 1'b1;
    tick; start = 1'b0;
    vectors++;
    if ({dp_clear, busy, feat_rd_en} !== 3'b110) begin
      errors++; $display("FAIL single_clear: clr/busy/rd=%b want 110", {dp_clear, busy, feat_rd_en});
    end
    tick;
    for (int i = 0; i < IMG; i++) begin
      if (feat_rd_en !== 1'b1 || feat_rd_addr !== 10'(i) || feature_in_valid !== (i > 0) || busy !== 1'b1)
        bad_rd++;
      tick;
    end
    vectors++;
    if (bad_rd != 0) begin
      errors++; $display("FAIL single_stream: %0d bad read cycles want 0", bad_rd);
    end
    vectors++;
    if ({feat_rd_en, feature_in_valid} !== 2'b01) begin
      errors++; $display("FAIL single_trailing_valid: rd/valid=%b want 01", {feat_rd_en, feature_in_valid});
    end
    for (int i = 0; i < 49; i++) tick;
    dp_done = 1'b1;
    tick;
    vectors++;
    if ({result_we, result_idx, kernel_sel} !== {1'b1, 8'd0, 8'd0}) begin
      errors++; $display("FAIL single_store: we=%b idx=%0d ksel=%0d want 1 0 0", result_we, result_idx, kernel_sel);
    end
    tick;
    vectors++;
    if ({layer_done, busy, result_we} !== 3'b110) begin
      errors++; $display("FAIL single_done: done/busy/we=%b want 110", {layer_done, busy, result_we});
    end
    tick;
    dp_done = 1'b0;
    vectors++;
    if ({layer_done, busy, n_we, n_done, n_clr} !== {2'b00, 32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL single_idle: done=%b busy=%b we=%0d ld=%0d clr=%0d want 0 0 1 1 1",
                         layer_done, busy, n_we, n_done, n_clr);
    end
  endtask

  task automatic test_three;
    int bad = 0;
    clr_counts();
    num_kernels = 8'd3; start = 1'b1;
    tick; start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (dp_clear !== 1'b1 || kernel_sel !== 8'(p)) bad++;
      tick;
      for (int i = 0; i < IMG; i++) begin
        if (feat_rd_en !== 1'b1 || feat_rd_addr !== 10'(i) || kernel_sel !== 8'(p)) bad++;
        tick;
      end
      dp_done = 1'b1;
      tick;
      dp_done = 1'b0;
      vectors++;
      if ({result_we, result_idx, kernel_sel} !== {1'b1, 8'(p), 8'(p)}) begin
        errors++; $display("FAIL three_store%0d: we=%b idx=%0d ksel=%0d want 1 %0d %0d",
                           p, result_we, result_idx, kernel_sel, p, p);
      end
      tick;
    end
    vectors++;
    if (layer_done !== 1'b1) begin
      errors++; $display("FAIL three_done: layer_done=%b want 1", layer_done);
    end
    tick;
    vectors++;
    if (bad != 0 || n_we != 3 || n_done != 1 || n_clr != 3 || busy !== 1'b0) begin
      errors++; $display("FAIL three_totals: bad=%0d we=%0d ld=%0d clr=%0d busy=%b want 0 3 1 3 0",
                         bad, n_we, n_done, n_clr, busy);
    end
  endtask

  task automatic test_timeout;
    int bad = 0;
    clr_counts();
    num_kernels = 8'd1; start = 1'b1;
    tick; start = 1'b0;
    tick;
    for (int i = 0; i < IMG; i++) tick;
    for (int i = 0; i < TO - 1; i++) begin
      if (timeout_err !== 1'b0 || layer_done !== 1'b0 || busy !== 1'b1) bad++;
      tick;
    end
    vectors++;
    if (bad != 0) begin
      errors++; $display("FAIL timeout_early: %0d cycles ended early want 0", bad);
    end
    tick;
    vectors++;
    if ({timeout_err, layer_done, result_we} !== 3'b110) begin
      errors++; $display("FAIL timeout_fire: err/done/we=%b want 110", {timeout_err, layer_done, result_we});
    end
    tick;
    vectors++;
    if ({timeout_err, busy} !== 2'b10 || n_we != 0) begin
      errors++; $display("FAIL timeout_sticky: err=%b busy=%b we=%0d want 1 0 0", timeout_err, busy, n_we);
    end
    start = 1'b1;
    tick; start = 1'b0;
    vectors++;
    if ({timeout_err, dp_clear} !== 2'b01) begin
      errors++; $display("FAIL timeout_clear_on_start: err/clr=%b want 01", {timeout_err, dp_clear});
    end
    abort = 1'b1;
    tick; abort = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    clr_counts();
    num_kernels = 8'd2; start = 1'b1;
    tick; start = 1'b0;
    tick;
    for (int i = 0; i < 100; i++) tick;
    vectors++;
    if ({feat_rd_en, feat_rd_addr} !== {1'b1, 10'd100}) begin
      errors++; $display("FAIL abort_addr: rd=%b addr=%0d want 1 100", feat_rd_en, feat_rd_addr);
    end
    abort = 1'b1;
    tick; abort = 1'b0;
    vectors++;
    if ({feat_rd_en, busy, feature_in_valid} !== 3'b001) begin
      errors++; $display("FAIL abort_idle: rd/busy/valid=%b want 001", {feat_rd_en, busy, feature_in_valid});
    end
    tick; tick;
    vectors++;
    if (feature_in_valid !== 1'b0 || n_done != 0 || n_we != 0) begin
      errors++; $display("FAIL abort_quiet: valid=%b ld=%0d we=%0d want 0 0 0", feature_in_valid, n_done, n_we);
    end
    num_kernels = 8'd1; start = 1'b1;
    tick; start = 1'b0;
    tick;
    vectors++;
    if ({feat_rd_en, feat_rd_addr, kernel_sel} !== {1'b1, 10'd0, 8'd0}) begin
      errors++; $display("FAIL abort_restart: rd=%b addr=%0d ksel=%0d want 1 0 0", feat_rd_en, feat_rd_addr, kernel_sel);
    end
    abort = 1'b1;
    tick; abort = 1'b0;
    tick;
  endtask

  task automatic test_zero_and_stuck;
    clr_counts();
    num_kernels = 8'd0; start = 1'b1;
    tick; start = 1'b0;
    vectors++;
    if ({layer_done, busy, dp_clear} !== 3'b110) begin
      errors++; $display("FAIL zero_done: done/busy/clr=%b want 110", {layer_done, busy, dp_clear});
    end
    tick;
    vectors++;
    if ({layer_done, busy} !== 2'b00 || n_clr != 0 || feat_rd_en !== 1'b0) begin
      errors++; $display("FAIL zero_idle: done=%b busy=%b clr=%0d rd=%b want 0 0 0 0", layer_done, busy, n_clr, feat_rd_en);
    end
    clr_counts();
    num_kernels = 8'd1; start = 1'b1;
    tick; start = 1'b0;
    tick;
    for (int i = 0; i < IMG; i++) begin
      if (i == 700) dp_done = 1'b1;
      tick;
    end
    for (int i = 0; i < 20; i++) tick;
    vectors++;
    if (n_we != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL stuck_high_no_store: we=%0d busy=%b want 0 1", n_we, busy);
    end
    dp_done = 1'b0;
    tick; tick;
    dp_done = 1'b1;
    tick;
    vectors++;
    if ({result_we, result_idx} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL stuck_high_store: we=%b idx=%0d want 1 0", result_we, result_idx);
    end
    tick; tick;
    dp_done = 1'b0;
  endtask

  task automatic test_busy_start;
    clr_counts();
    num_kernels = 8'd1; start = 1'b1;
    tick; start = 1'b0;
    tick;
    for (int i = 0; i < 10; i++) tick;
    num_kernels = 8'd3; start = 1'b1;
    tick; start = 1'b0;
    for (int i = 11; i < IMG; i++) tick;
    dp_done = 1'b1;
    tick;
    dp_done = 1'b0;
    tick;
    vectors++;
    if ({layer_done, dp_clear} !== 2'b10) begin
      errors++; $display("FAIL busy_start_ignored: done/clr=%b want 10", {layer_done, dp_clear});
    end
    tick;
    vectors++;
    if (n_we != 1 || n_clr != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_passes: we=%0d clr=%0d busy=%b want 1 1 0", n_we, n_clr, busy);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [39:0] all_out;
    num_kernels = 8'd2; start = 1'b1;
    tick; start = 1'b0;
    tick;
    for (int i = 0; i < IMG; i++) tick;
    for (int i = 0; i < 10; i++) tick;
    vectors++;
    if ({busy, feature_in_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_pre_wait: busy/valid=%b want 10", {busy, feature_in_valid});
    end
    rst = 1'b1;
    tick; rst = 1'b0;
    all_out = {dp_clear, feat_rd_en, feat_rd_addr, feature_in_valid, kernel_sel,
               result_we, result_idx, busy, layer_done, timeout_err};
    vectors++;
    if (all_out !== 40'd0) begin
      errors++; $display("FAIL reset_mid_wait: got %h want 0", all_out);
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_timeout();
    test_abort();
    test_zero_and_stuck();
    test_busy_start();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
